// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: access-size encodings, dump FSM
// states, byte-lane constants and a byte-enable helper.
package mem_pkg;

  // Access size as carried on i_size. 2'b10 is not listed here and is
  // handled as a word access.
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b11;

  // Byte lanes within a 32-bit word, little-endian.
  localparam int unsigned NUM_LANES = 4;
  localparam logic [1:0]  LANE0     = 2'd0;
  localparam logic [1:0]  LANE1     = 2'd1;
  localparam logic [1:0]  LANE2     = 2'd2;
  localparam logic [1:0]  LANE3     = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DUMP,
    ST_DONE
  } dump_state_t;

  // Byte enables for an aligned access of the given size at byte offset low.
  function automatic logic [NUM_LANES-1:0] lane_mask(input logic [1:0] size,
                                                     input logic [1:0] low);
    logic [NUM_LANES-1:0] m;
    m = '0;
    case (size)
      SIZE_BYTE: begin
        case (low)
          LANE0:   m = 4'b0001;
          LANE1:   m = 4'b0010;
          LANE2:   m = 4'b0100;
          default: m = 4'b1000;
        endcase
      end
      SIZE_HALF: m = low[1] ? 4'b1100 : 4'b0011;
      default:   m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/data_mem.sv
// Data memory: 2**MEM_ADDR_W words of INST_SZ bits, not reset.
// Ports:
//   clk        write clock
//   be         per-byte write enables (all zero = no write)
//   waddr      word address of the write
//   wdata      write data, already steered onto its byte lanes
//   raddr      pipeline read word address, rdata its asynchronous data
//   dump_addr  dump read word address, dump_data its asynchronous data
module data_mem
  import mem_pkg::*;
#(
  parameter int unsigned INST_SZ    = 32,
  parameter int unsigned MEM_ADDR_W = 8
) (
  input  logic                  clk,
  input  logic [NUM_LANES-1:0]  be,
  input  logic [MEM_ADDR_W-1:0] waddr,
  input  logic [INST_SZ-1:0]    wdata,
  input  logic [MEM_ADDR_W-1:0] raddr,
  output logic [INST_SZ-1:0]    rdata,
  input  logic [MEM_ADDR_W-1:0] dump_addr,
  output logic [INST_SZ-1:0]    dump_data
);

  localparam int unsigned DEPTH = 2 ** MEM_ADDR_W;

  logic [INST_SZ-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (be[i]) begin
        mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata     = mem[raddr];
  assign dump_data = mem[dump_addr];

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: aligned byte/half/word loads and stores into the data
// memory with sign/zero extension, plus a dump engine that streams the whole
// memory to the debug unit over valid/ready once the pipeline has halted.
// Ports:
//   i_clk, i_reset         clock, asynchronous active-high reset
//   i_enable               pipeline advance; low blocks stores
//   i_mem_read/i_mem_write access controls
//   i_size, i_unsigned     access size and load extension mode
//   i_addr, i_write_data   byte address and right-justified store data
//   o_read_data            extended load data (combinational)
//   o_misaligned           current access is misaligned (combinational)
//   i_halted, i_dump_start dump request qualifiers
//   i_dump_ready           debug unit accepts current dump word
//   o_dump_valid/addr/data current dump word
//   o_dump_done            one-cycle pulse after the last word is accepted
//   o_busy                 dump in progress (stores are blocked)
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int unsigned INST_SZ    = 32,
  parameter int unsigned MEM_ADDR_W = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic                  i_mem_read,
  input  logic                  i_mem_write,
  input  logic [1:0]            i_size,
  input  logic                  i_unsigned,
  input  logic [INST_SZ-1:0]    i_addr,
  input  logic [INST_SZ-1:0]    i_write_data,
  input  logic                  i_halted,
  input  logic                  i_dump_start,
  input  logic                  i_dump_ready,
  output logic [INST_SZ-1:0]    o_read_data,
  output logic                  o_misaligned,
  output logic                  o_dump_valid,
  output logic [MEM_ADDR_W-1:0] o_dump_addr,
  output logic [INST_SZ-1:0]    o_dump_data,
  output logic                  o_dump_done,
  output logic                  o_busy
);

  logic [MEM_ADDR_W-1:0] word_idx;
  logic [1:0]            low;
  logic                  mis_raw;
  logic [NUM_LANES-1:0]  be;
  logic [INST_SZ-1:0]    wdata;
  logic [INST_SZ-1:0]    rword;
  logic [7:0]            rbyte;
  logic [15:0]           rhalf;
  logic                  sbit;
  logic [INST_SZ-1:0]    load_val;
  dump_state_t           state;
  logic [MEM_ADDR_W-1:0] ptr;

  // Address bits above the word index only wrap the access; they are
  // deliberately discarded.
  logic unused_addr_bits;
  assign unused_addr_bits = ^i_addr[INST_SZ-1:MEM_ADDR_W+2];

  assign word_idx = i_addr[MEM_ADDR_W+1:2];
  assign low      = i_addr[1:0];

  always_comb begin
    mis_raw = 1'b0;
    case (i_size)
      SIZE_BYTE: mis_raw = 1'b0;
      SIZE_HALF: mis_raw = low[0];
      default:   mis_raw = (low != 2'b00);
    endcase
  end

  assign o_misaligned = mis_raw & (i_mem_read | i_mem_write);

  // Store steering: replicate the low bits across every lane and let the
  // byte enables pick the addressed one.
  always_comb begin
    case (i_size)
      SIZE_BYTE: wdata = {4{i_write_data[7:0]}};
      SIZE_HALF: wdata = {2{i_write_data[15:0]}};
      default:   wdata = i_write_data;
    endcase
    if (i_enable & i_mem_write & ~o_misaligned & ~o_busy) begin
      be = lane_mask(i_size, low);
    end else begin
      be = '0;
    end
  end

  data_mem #(
    .INST_SZ   (INST_SZ),
    .MEM_ADDR_W(MEM_ADDR_W)
  ) u_data_mem (
    .clk      (i_clk),
    .be       (be),
    .waddr    (word_idx),
    .wdata    (wdata),
    .raddr    (word_idx),
    .rdata    (rword),
    .dump_addr(ptr),
    .dump_data(o_dump_data)
  );

  // Load alignment and extension.
  always_comb begin
    rbyte    = rword[{low, 3'b000} +: 8];
    rhalf    = low[1] ? rword[31:16] : rword[15:0];
    sbit     = 1'b0;
    load_val = rword;
    case (i_size)
      SIZE_BYTE: begin
        sbit     = rbyte[7] & ~i_unsigned;
        load_val = {{(INST_SZ-8){sbit}}, rbyte};
      end
      SIZE_HALF: begin
        sbit     = rhalf[15] & ~i_unsigned;
        load_val = {{(INST_SZ-16){sbit}}, rhalf};
      end
      default: load_val = rword;
    endcase
    o_read_data = (i_mem_read & ~mis_raw) ? load_val : '0;
  end

  assign o_dump_addr = ptr;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state        <= ST_IDLE;
      ptr          <= '0;
      o_dump_valid <= 1'b0;
      o_dump_done  <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          o_dump_done <= 1'b0;
          if (i_dump_start & i_halted) begin
            state        <= ST_DUMP;
            ptr          <= '0;
            o_dump_valid <= 1'b1;
            o_busy       <= 1'b1;
          end
        end
        ST_DUMP: begin
          if (i_dump_ready) begin
            // Pointer wraps back to 0 on the final accept.
            ptr <= ptr + 1'b1;
            if (ptr == '1) begin
              state        <= ST_DONE;
              o_dump_valid <= 1'b0;
              o_busy       <= 1'b0;
              o_dump_done  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          o_dump_done <= 1'b0;
          state       <= ST_IDLE;
        end
        default: begin
          state        <= ST_IDLE;
          o_dump_valid <= 1'b0;
          o_busy       <= 1'b0;
          o_dump_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 2 ** AW;
  localparam int unsigned NBYTE = DEPTH * 4;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          i_enable;
  logic          i_mem_read;
  logic          i_mem_write;
  logic [1:0]    i_size;
  logic          i_unsigned;
  logic [31:0]   i_addr;
  logic [31:0]   i_write_data;
  logic          i_halted;
  logic          i_dump_start;
  logic          i_dump_ready;
  logic [31:0]   o_read_data;
  logic          o_misaligned;
  logic          o_dump_valid;
  logic [AW-1:0] o_dump_addr;
  logic [31:0]   o_dump_data;
  logic          o_dump_done;
  logic          o_busy;

  mem_access_stage #(
    .INST_SZ   (32),
    .MEM_ADDR_W(AW)
  ) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_enable    (i_enable),
    .i_mem_read  (i_mem_read),
    .i_mem_write (i_mem_write),
    .i_size      (i_size),
    .i_unsigned  (i_unsigned),
    .i_addr      (i_addr),
    .i_write_data(i_write_data),
    .i_halted    (i_halted),
    .i_dump_start(i_dump_start),
    .i_dump_ready(i_dump_ready),
    .o_read_data (o_read_data),
    .o_misaligned(o_misaligned),
    .o_dump_valid(o_dump_valid),
    .o_dump_addr (o_dump_addr),
    .o_dump_data (o_dump_data),
    .o_dump_done (o_dump_done),
    .o_busy      (o_busy)
  );

  always #5 i_clk = ~i_clk;

  int passed = 0;
  int total  = 0;

  // Reference memory as a flat little-endian byte array.
  logic [7:0] mb [NBYTE];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  function automatic int unsigned nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic model_mis(input logic [1:0] sz, input logic [31:0] addr);
    return (addr % nbytes(sz)) != 0;
  endfunction

  function automatic logic [31:0] model_word(input int unsigned w);
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < 4; k++) v = v | (32'(mb[(w % DEPTH) * 4 + k]) << (8 * k));
    return v;
  endfunction

  function automatic logic [31:0] model_load(input logic rd, input logic [1:0] sz,
                                             input logic uns, input logic [31:0] addr);
    int unsigned n, base;
    logic [31:0] v, top;
    if (!rd || model_mis(sz, addr)) return '0;
    n    = nbytes(sz);
    base = addr % NBYTE;
    v    = '0;
    for (int unsigned k = 0; k < n; k++) v = v | (32'(mb[base + k]) << (8 * k));
    if (n < 4 && !uns) begin
      top = (32'h1 << (8 * n)) - 1;
      if (v[8*n-1]) v = v | ~top;
    end
    return v;
  endfunction

  task automatic model_store(input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] wd);
    int unsigned base;
    base = addr % NBYTE;
    for (int unsigned k = 0; k < nbytes(sz); k++) mb[base + k] = 8'(wd >> (8 * k));
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd, input logic en);
    i_mem_read   = rd;
    i_mem_write  = wr;
    i_size       = sz;
    i_unsigned   = uns;
    i_addr       = addr;
    i_write_data = wd;
    i_enable     = en;
  endtask

  // One pipeline cycle checked against the reference model.
  task automatic model_cycle(input string name, input logic rd, input logic wr,
                             input logic [1:0] sz, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wd, input logic en);
    logic mis;
    @(negedge i_clk);
    drive(rd, wr, sz, uns, addr, wd, en);
    mis = (rd | wr) & model_mis(sz, addr);
    #1;
    check({name, "_rdata"}, o_read_data, model_load(rd, sz, uns, addr));
    check({name, "_mis"}, 32'(o_misaligned), 32'(mis));
    @(posedge i_clk);
    if (en && wr && !mis) model_store(sz, addr, wd);
  endtask

  typedef struct {
    logic        rd, wr, uns, en;
    logic [1:0]  sz;
    logic [31:0] addr, wd, exp_rd;
    logic        exp_mis;
  } vec_t;

  vec_t vt [18];

  function automatic vec_t mk(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wd, input logic en,
                              input logic [31:0] exp_rd, input logic exp_mis);
    vec_t v;
    v.rd = rd; v.wr = wr; v.sz = sz; v.uns = uns; v.addr = addr; v.wd = wd; v.en = en;
    v.exp_rd = exp_rd; v.exp_mis = exp_mis;
    return v;
  endfunction

  initial begin
    int unsigned ptr, cyc;
    bit          finished;
    bit          pat [5];
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    i_reset = 1'b1;
    i_halted = 1'b0;
    i_dump_start = 1'b0;
    i_dump_ready = 1'b0;
    drive(1'b0, 1'b0, 2'b11, 1'b0, '0, '0, 1'b0);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    check("rst_valid", 32'(o_dump_valid), 0);
    check("rst_done", 32'(o_dump_done), 0);
    check("rst_busy", 32'(o_busy), 0);
    i_reset = 1'b0;

    // Initialise every word so the model and memory agree.
    for (int unsigned w = 0; w < DEPTH; w++) begin
      @(negedge i_clk);
      drive(1'b0, 1'b1, 2'b11, 1'b0, 32'(w * 4), 32'hA500_0000 | w, 1'b1);
      @(posedge i_clk);
      model_store(2'b11, 32'(w * 4), 32'hA500_0000 | w);
    end

    vt[0]  = mk(0, 1, 2'b11, 0, 32'h10, 32'hDEADBEEF, 1, 32'h0, 0);
    vt[1]  = mk(1, 0, 2'b11, 0, 32'h10, 32'h0, 1, 32'hDEADBEEF, 0);
    vt[2]  = mk(0, 1, 2'b00, 0, 32'h13, 32'h80, 1, 32'h0, 0);
    vt[3]  = mk(1, 0, 2'b00, 0, 32'h13, 32'h0, 1, 32'hFFFFFF80, 0);
    vt[4]  = mk(1, 0, 2'b00, 1, 32'h13, 32'h0, 1, 32'h00000080, 0);
    vt[5]  = mk(1, 0, 2'b11, 0, 32'h10, 32'h0, 1, 32'h80ADBEEF, 0);
    vt[6]  = mk(0, 1, 2'b01, 0, 32'h21, 32'h1234, 1, 32'h0, 1);
    vt[7]  = mk(1, 0, 2'b11, 0, 32'h20, 32'h0, 1, 32'hA5000008, 0);
    vt[8]  = mk(1, 0, 2'b11, 0, 32'h22, 32'h0, 1, 32'h0, 1);
    vt[9]  = mk(0, 1, 2'b11, 0, 32'h20, 32'h11223344, 0, 32'h0, 0);
    vt[10] = mk(1, 0, 2'b11, 0, 32'h20, 32'h0, 1, 32'hA5000008, 0);
    vt[11] = mk(1, 0, 2'b01, 0, 32'h12, 32'h0, 1, 32'hFFFF80AD, 0);
    vt[12] = mk(1, 0, 2'b01, 1, 32'h10, 32'h0, 1, 32'h0000BEEF, 0);
    vt[13] = mk(1, 0, 2'b10, 0, 32'h10, 32'h0, 1, 32'h80ADBEEF, 0);
    vt[14] = mk(1, 1, 2'b11, 0, 32'h10, 32'h55667788, 1, 32'h80ADBEEF, 0);
    vt[15] = mk(1, 0, 2'b11, 0, 32'h10, 32'h0, 1, 32'h55667788, 0);
    vt[16] = mk(0, 0, 2'b01, 0, 32'h21, 32'h0, 1, 32'h0, 0);
    vt[17] = mk(1, 0, 2'b11, 0, 32'h50, 32'h0, 1, 32'h55667788, 0);

    foreach (vt[i]) begin
      @(negedge i_clk);
      drive(vt[i].rd, vt[i].wr, vt[i].sz, vt[i].uns, vt[i].addr, vt[i].wd, vt[i].en);
      #1;
      check($sformatf("vec%0d_rdata", i), o_read_data, vt[i].exp_rd);
      check($sformatf("vec%0d_mis", i), 32'(o_misaligned), 32'(vt[i].exp_mis));
      @(posedge i_clk);
      if (vt[i].en && vt[i].wr && !vt[i].exp_mis) model_store(vt[i].sz, vt[i].addr, vt[i].wd);
    end

    // Randomised accesses against the byte-array model.
    for (int i = 0; i < 300; i++) begin
      logic [1:0] sz;
      sz = 2'($urandom_range(0, 3));
      model_cycle("rand", 1'($urandom), 1'($urandom), sz, 1'($urandom),
                  $urandom, $urandom, 1'($urandom_range(0, 3) != 0));
    end

    // Preload 1..DEPTH for the dump.
    for (int unsigned w = 0; w < DEPTH; w++)
      model_cycle("preload", 1'b0, 1'b1, 2'b11, 1'b0, 32'(w * 4), 32'(w + 1), 1'b1);

    // Start without halt is ignored.
    @(negedge i_clk);
    drive(1'b0, 1'b0, 2'b11, 1'b0, '0, '0, 1'b1);
    i_dump_start = 1'b1;
    @(negedge i_clk);
    i_dump_start = 1'b0;
    #1;
    check("nohalt_valid", 32'(o_dump_valid), 0);
    check("nohalt_busy", 32'(o_busy), 0);

    // Full dump with ready pattern 1,0,1,1,1 and a store attempted throughout.
    i_halted = 1'b1;
    @(negedge i_clk);
    i_dump_start = 1'b1;
    @(negedge i_clk);
    i_dump_start = 1'b0;
    drive(1'b0, 1'b1, 2'b11, 1'b0, 32'h0, 32'hFFFF_FFFF, 1'b1);
    ptr = 0;
    cyc = 0;
    finished = 1'b0;
    while (!finished && cyc < 200) begin
      if (cyc != 0) @(negedge i_clk);
      i_dump_ready = pat[cyc % 5];
      #1;
      check("dump_valid", 32'(o_dump_valid), 1);
      check("dump_busy", 32'(o_busy), 1);
      check("dump_addr", 32'(o_dump_addr), 32'(ptr % DEPTH));
      check("dump_data", o_dump_data, model_word(ptr));
      @(posedge i_clk);
      if (i_dump_ready) begin
        if (ptr == DEPTH - 1) finished = 1'b1;
        ptr++;
      end
      cyc++;
    end
    if (!finished) check("dump_timeout", 32'(finished), 1);
    @(negedge i_clk);
    i_dump_ready = 1'b0;
    drive(1'b0, 1'b0, 2'b11, 1'b0, '0, '0, 1'b1);
    #1;
    check("done_pulse", 32'(o_dump_done), 1);
    check("done_busy", 32'(o_busy), 0);
    check("done_valid", 32'(o_dump_valid), 0);
    @(negedge i_clk);
    #1;
    check("done_clear", 32'(o_dump_done), 0);
    model_cycle("blocked_store", 1'b1, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1);
    check("blocked_word0", model_word(0), 32'd1);

    // Reset in the middle of a dump, then restart.
    @(negedge i_clk);
    i_dump_start = 1'b1;
    @(negedge i_clk);
    i_dump_start = 1'b0;
    i_dump_ready = 1'b1;
    repeat (2) @(negedge i_clk);
    i_dump_ready = 1'b0;
    #1;
    check("mid_addr", 32'(o_dump_addr), 2);
    i_reset = 1'b1;
    #1;
    check("rstdump_valid", 32'(o_dump_valid), 0);
    check("rstdump_busy", 32'(o_busy), 0);
    check("rstdump_addr", 32'(o_dump_addr), 0);
    @(negedge i_clk);
    i_reset = 1'b0;
    i_dump_start = 1'b1;
    @(negedge i_clk);
    i_dump_start = 1'b0;
    #1;
    check("restart_valid", 32'(o_dump_valid), 1);
    check("restart_addr", 32'(o_dump_addr), 0);
    check("restart_data", o_dump_data, 32'd1);
    @(negedge i_clk);
    i_reset = 1'b1;
    @(negedge i_clk);
    i_reset = 1'b0;
    i_halted = 1'b0;
    for (int unsigned w = 0; w < DEPTH; w++)
      model_cycle("intact", 1'b1, 1'b0, 2'b11, 1'b0, 32'(w * 4), 32'h0, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
MEM stage of the 5-stage MIPS pipeline, directly upstream of the MEM/WB register. Holds the data memory and performs aligned byte/half/word loads and stores, with sign or zero extension. Load data goes combinationally to the MEM/WB read-data input. A dump FSM streams the whole memory to the debug unit over a valid/ready handshake once the pipeline has halted.

Parameters:
INST_SZ, 32, datapath width in bits
MEM_ADDR_W, 8, word-address width; depth = 2**MEM_ADDR_W words

Ports:
i_clk  in  1  clock
i_reset  in  1  reset, asynchronous, active-high
i_enable  in  1  pipeline advance; 0 = stall, which blocks stores
i_mem_read  in  1  MemRead control line
i_mem_write  in  1  MemWrite control line
i_size  in  2  access size: 00 byte, 01 half, 11 word (10 is treated as word)
i_unsigned  in  1  1 = zero-extend loads, 0 = sign-extend
i_addr  in  INST_SZ  byte address (the ALU result)
i_write_data  in  INST_SZ  store data, right-justified
i_halted  in  1  pipeline halted (the halt bit has reached WB)
i_dump_start  in  1  pulse that requests a memory dump
i_dump_ready  in  1  debug unit accepts the current word
o_read_data  out  INST_SZ  extended load data, combinational
o_misaligned  out  1  current access is misaligned, combinational
o_dump_valid  out  1  dump word is valid
o_dump_addr  out  MEM_ADDR_W  word index of the dump word
o_dump_data  out  INST_SZ  dump word
o_dump_done  out  1  one-cycle pulse after the last word is accepted
o_busy  out  1  dump in progress

Behaviour:
- One clock, i_clk. Reset is asynchronous and active-high on i_reset.
- Reset values: FSM=IDLE, pointer=0, o_dump_valid=0, o_dump_done=0, o_busy=0.
- The memory array is never reset; its contents survive i_reset.
- Word index = i_addr[MEM_ADDR_W+1:2]. Address bits above that are ignored, so accesses wrap modulo the depth.
- Misalignment:
  - half with i_addr[0]=1, or word with i_addr[1:0]!=0, sets o_misaligned=1.
  - o_misaligned is gated by i_mem_read|i_mem_write.
  - A misaligned store writes nothing; a misaligned load returns 0.
- Loads: asynchronous read with 0-cycle latency.
  - Byte lane = i_addr[1:0]; lane 0 is bits [7:0] (little-endian).
  - Half lane = i_addr[1].
  - Extension follows i_unsigned.
  - o_read_data=0 when i_mem_read=0.
- Stores: written on the posedge when i_enable & i_mem_write & ~o_misaligned & ~o_busy.
  - Byte/half data is taken from the low bits of i_write_data and placed on the addressed lane via byte enables.
  - Other bytes of the word are untouched.
- Load and store to the same word in the same cycle: the load returns the old contents.
- Dump FSM states: IDLE, DUMP, DONE.
  - IDLE -> DUMP when i_dump_start & i_halted. Pointer <= 0.
  - i_dump_start is ignored outside IDLE or while i_halted=0.
  - DUMP: o_busy=1, o_dump_valid=1, o_dump_addr=pointer, o_dump_data=mem[pointer] (second async read port).
  - On valid & i_dump_ready the pointer increments. The pointer does not advance without ready, and addr/data stay stable.
  - DUMP -> DONE when the word at pointer = 2**MEM_ADDR_W-1 is accepted.
  - DONE: o_dump_done=1 for exactly one cycle, o_busy=0, then IDLE.
- i_reset during DUMP: immediately IDLE, valid=0, pointer=0. A later start restarts from word 0.
- i_enable has no effect on the dump FSM.

Decomposition:
- Shared package mem_pkg:
  - size encodings SIZE_BYTE/SIZE_HALF/SIZE_WORD
  - dump FSM state encodings (IDLE/DUMP/DONE)
  - byte-lane constants
- Sub-module data_mem: RAM array with 4-bit byte-enable write port and two asynchronous read ports (pipeline and dump).
- Load alignment/extension, store lane steering and the FSM stay in mem_access_stage.

Test Plan:
1. Store word 0xDEADBEEF at addr 0x10; load word signed from 0x10 -> o_read_data=0xDEADBEEF, o_misaligned=0.
2. Store byte 0x80 at 0x13, then:
   - load byte signed from 0x13 -> 0xFFFFFF80
   - load byte unsigned -> 0x00000080
   - load word from 0x10 -> 0x80ADBEEF
3. Store half 0x1234 at 0x21 -> o_misaligned=1 and word 0x20 unchanged. Load word from 0x22 -> o_misaligned=1, o_read_data=0. Store with i_enable=0 -> no write.
4. MEM_ADDR_W=2, memory preloaded with 1..4, i_halted=1, pulse i_dump_start; i_dump_ready toggles 1,0,1,1,1 -> words 1,2,3,4 at addr 0..3, stable while ready=0. o_dump_done pulses once after word 4. Stores during DUMP are blocked.
5. i_dump_start while i_halted=0 -> stays IDLE. Assert i_reset mid-dump at pointer 2 -> valid drops immediately; restart begins at word 0 and memory contents are intact.
